// File: rtl/mor1kx_fetch_pkg.sv
// Shared types for the buffered fetch unit: FSM states, prefetch entry layout, NOP encoding.
`ifndef OR1K_OPCODE_NOP
`define OR1K_OPCODE_NOP 6'h05
`endif

package mor1kx_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    DISCARD  = 2'd1,
    ERR_WAIT = 2'd2
  } fetch_state_t;

  // Entries carry the widest supported PC; narrower builds zero-extend on push.
  localparam int FETCH_PC_MAX_W = 64;

  localparam logic [31:0] FETCH_NOP_INSN = {`OR1K_OPCODE_NOP, 26'd0};

  typedef struct packed {
    logic [31:0]               insn;
    logic [FETCH_PC_MAX_W-1:0] pc;
    logic                      err;
  } fetch_entry_t;

endpackage

// File: rtl/mor1kx_fetch_fifo.sv
// Power-of-two FIFO with occupancy count and synchronous flush; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module mor1kx_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mor1kx_fetch_buffered.sv
// Buffered instruction fetch: keeps up to FETCH_BUF_DEPTH prefetched instructions ahead of decode.
// Optional MOR1KX_FETCH_SEQ_BYPASS_EN: an ack into an empty buffer feeds decode directly.
`ifndef OR1K_RESET_VECTOR
`define OR1K_RESET_VECTOR 5'h01
`endif

module mor1kx_fetch_buffered
  import mor1kx_fetch_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC = {19'd0, `OR1K_RESET_VECTOR, 8'd0},
  parameter int FETCH_BUF_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_req_o,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i,
  input  logic [31:0]                     ibus_dat_i,
  input  logic                            padv_i,
  input  logic                            branch_occur_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] branch_dest_i,
  input  logic                            fetch_take_exception_branch_i,
  input  logic                            du_restart_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] du_restart_pc_i,
  input  logic                            du_stall_i,
  output logic [31:0]                     decode_insn_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_o,
  output logic                            decode_except_ibus_err_o,
  output logic                            next_fetch_done_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] fetch_rfa_adr_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] fetch_rfb_adr_o,
  output logic                            fetch_advancing_o
);

  localparam int CNT_W = $clog2(FETCH_BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FETCH_BUF_DEPTH);

  fetch_state_t                    state;
  fetch_state_t                    state_nxt;
  logic [OPTION_OPERAND_WIDTH-1:0] fetch_pc;
  logic [OPTION_OPERAND_WIDTH-1:0] fetch_pc_nxt;
  logic [OPTION_OPERAND_WIDTH-1:0] discard_adr;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc;
  logic                            pending;
  logic                            fetch_req;
  logic                            ack_ok;
  logic                            err_ok;
  logic                            redirect;
  logic                            pop;
  logic                            push;
  logic                            bypass;
  logic                            fifo_empty;
  logic [CNT_W-1:0]                fifo_count;
  fetch_entry_t                    push_entry;
  fetch_entry_t                    head;
  logic                            unused_head_pc;

  assign redirect    = du_restart_i | fetch_take_exception_branch_i | (branch_occur_i & padv_i);
  assign redirect_pc = du_restart_i ? du_restart_pc_i : branch_dest_i;

  // Counting the buffered entries before issuing guarantees room for the one outstanding response.
  assign fetch_req = (state == FETCH)   ? (pending | ((fifo_count < DEPTH_CNT) & ~du_stall_i)) :
                     (state == DISCARD);
  assign ack_ok    = fetch_req & ibus_ack_i;
  assign err_ok    = fetch_req & ibus_err_i & ~ibus_ack_i;

  assign ibus_req_o = fetch_req;
  assign ibus_adr_o = (state == DISCARD) ? discard_adr : fetch_pc;

  assign next_fetch_done_o = ~fifo_empty;
  assign pop               = padv_i & ~fifo_empty & ~redirect;
  assign fetch_advancing_o = pop;
  assign fetch_rfa_adr_o   = head.insn[16 +: OPTION_RF_ADDR_WIDTH];
  assign fetch_rfb_adr_o   = head.insn[11 +: OPTION_RF_ADDR_WIDTH];
  assign unused_head_pc    = ^head.pc;

`ifdef MOR1KX_FETCH_SEQ_BYPASS_EN
  assign bypass = (state == FETCH) & fifo_empty & ack_ok & padv_i & ~redirect & ~du_stall_i;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    push            = 1'b0;
    push_entry.insn = ibus_dat_i;
    push_entry.pc   = FETCH_PC_MAX_W'(fetch_pc);
    push_entry.err  = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          if (fetch_req & ~ack_ok & ~err_ok) state_nxt = DISCARD;
        end else if (err_ok) begin
          push            = 1'b1;
          push_entry.insn = FETCH_NOP_INSN;
          push_entry.err  = 1'b1;
          state_nxt       = ERR_WAIT;
        end else if (ack_ok) begin
          push         = ~bypass;
          fetch_pc_nxt = fetch_pc + OPTION_OPERAND_WIDTH'(4);
        end
      end
      DISCARD: begin
        // The stale response is swallowed here; a further redirect only retargets fetch_pc.
        if (redirect) fetch_pc_nxt = redirect_pc;
        if (ack_ok | err_ok) state_nxt = FETCH;
      end
      ERR_WAIT: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= OPTION_RESET_PC;
      pending  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      pending  <= (state == FETCH) & fetch_req & ~ack_ok & ~err_ok & ~redirect;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == FETCH) & redirect) discard_adr <= fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decode_insn_o            <= FETCH_NOP_INSN;
      decode_pc_o              <= OPTION_RESET_PC;
      decode_except_ibus_err_o <= 1'b0;
    end else if (redirect | du_stall_i) begin
      decode_insn_o            <= FETCH_NOP_INSN;
      decode_except_ibus_err_o <= 1'b0;
    end else if (pop) begin
      decode_insn_o            <= head.insn;
      decode_pc_o              <= head.pc[OPTION_OPERAND_WIDTH-1:0];
      decode_except_ibus_err_o <= head.err;
    end else if (bypass) begin
      decode_insn_o            <= ibus_dat_i;
      decode_pc_o              <= fetch_pc;
      decode_except_ibus_err_o <= 1'b0;
    end
  end

  mor1kx_fetch_fifo #(
    .DEPTH (FETCH_BUF_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
